// File: rtl/stl_tans_stream.sv
// stl_tans_stream: ping-pong row-to-column transposer.
// Rows of WY bits are written into one WX x WY bank while the other bank
// is drained column by column, so each output word is WX bits wide.
module stl_tans_stream #(
    parameter int WX = 4,
    parameter int WY = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WY-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WX-1:0] out_data,
    output logic          out_last
);

    localparam int XW = (WX > 1) ? $clog2(WX) : 1;
    localparam int YW = (WY > 1) ? $clog2(WY) : 1;
    localparam logic [XW-1:0] WCNT_LAST = XW'(WX - 1);
    localparam logic [YW-1:0] RCNT_LAST = YW'(WY - 1);

    // Two banks of WX rows each; contents only matter while the bank is full.
    logic [WY-1:0] mem [2][WX];

    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          wbank;
    logic          rbank;
    logic [XW-1:0] wcnt;
    logic [YW-1:0] rcnt;
    logic          wr_fire;
    logic          rd_fire;
    logic          wr_last;
    logic          rd_last;

    // Handshake status comes straight from registers, so in_ready never
    // depends on out_ready.
    assign in_ready  = ~full[wbank];
    assign out_valid = full[rbank];
    assign out_last  = out_valid & (rcnt == RCNT_LAST);

    // Flush wins over any handshake presented in the same cycle.
    assign wr_fire = in_valid & in_ready & ~flush;
    assign rd_fire = out_valid & out_ready & ~flush;
    assign wr_last = wr_fire & (wcnt == WCNT_LAST);
    assign rd_last = rd_fire & (rcnt == RCNT_LAST);

    // Column select: bit i of the output is row i of the read bank at column rcnt.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < WX; i++) begin
            out_data[i] = mem[rbank][i][rcnt];
        end
    end

    // Row storage; no reset needed because the full flags gate visibility.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wbank][wcnt] <= in_data;
        end
    end

    // Write side: row counter and bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank <= 1'b0;
            wcnt  <= '0;
        end else if (flush) begin
            wbank <= 1'b0;
            wcnt  <= '0;
        end else if (wr_fire) begin
            if (wcnt == WCNT_LAST) begin
                wcnt  <= '0;
                wbank <= ~wbank;
            end else begin
                wcnt <= wcnt + XW'(1);
            end
        end
    end

    // Read side: column counter and bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbank <= 1'b0;
            rcnt  <= '0;
        end else if (flush) begin
            rbank <= 1'b0;
            rcnt  <= '0;
        end else if (rd_fire) begin
            if (rcnt == RCNT_LAST) begin
                rcnt  <= '0;
                rbank <= ~rbank;
            end else begin
                rcnt <= rcnt + YW'(1);
            end
        end
    end

    // Full flags: a fill and a drain always target different banks, so both
    // updates can apply in the same cycle.
    always_comb begin
        full_nxt = full;
        if (wr_last) begin
            full_nxt[wbank] = 1'b1;
        end
        if (rd_last) begin
            full_nxt[rbank] = 1'b0;
        end
    end

    // Full flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else if (flush) begin
            full <= 2'b00;
        end else begin
            full <= full_nxt;
        end
    end

endmodule

// File: tb/tb_stl_tans_stream.sv
// Testbench for stl_tans_stream (WX=4, WY=5): directed scenarios plus a
// randomized stall test against a queue-based transpose model.
module tb_stl_tans_stream;

    localparam int WX = 4;
    localparam int WY = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [WY-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [WX-1:0] out_data;
    logic          out_last;

    int tests = 0;
    int fails = 0;

    logic [WY-1:0] single_rows [WX] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000};
    logic [WX-1:0] single_cols [WY] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

    stl_tans_stream #(.WX(WX), .WY(WY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Column j of a matrix: bit i is row i, element j.
    function automatic logic [WX-1:0] transpose_col(input logic [WY-1:0] rows [WX], input int j);
        logic [WX-1:0] c;
        c = '0;
        for (int i = 0; i < WX; i++) c[i] = rows[i][j];
        return c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        rst_n = 1'b1;
    endtask

    // Starts at the negedge where reset was released: first row goes in at once.
    task automatic test_single_matrix();
        logic exp_last;
        for (int k = 0; k < WX; k++) begin
            if (k != 0) @(negedge clk);
            in_valid = 1'b1; in_data = single_rows[k]; out_ready = 1'b1;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single_in_ready row %0d: got %b want 1", k, in_ready); end
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid row %0d: got %b want 0", k, out_valid); end
        end
        for (int c = 0; c < WY; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            exp_last = (c == WY - 1);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid col %0d: got %b want 1", c, out_valid); end
            tests++; if (out_data !== single_cols[c]) begin fails++; $display("FAIL single_col %0d: got %b want %b", c, out_data, single_cols[c]); end
            tests++; if (out_last !== exp_last) begin fails++; $display("FAIL single_last col %0d: got %b want %b", c, out_last, exp_last); end
        end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [WY-1:0] rows [12];
        logic [WX-1:0] exp_col;
        logic          exp_ir;
        logic          exp_last;
        int            acc;
        int            m;
        int            j;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            rows[k] = WY'($urandom);
            in_valid = 1'b1; in_data = rows[k]; out_ready = 1'b0;
            exp_ir = (k < 8);
            tests++; if (in_ready !== exp_ir) begin fails++; $display("FAIL bp_in_ready row %0d: got %b want %b", k, in_ready, exp_ir); end
            if (in_ready === 1'b1) acc++;
        end
        tests++; if (acc != 8) begin fails++; $display("FAIL bp_accepted: got %0d want 8", acc); end
        for (int c = 0; c < 2 * WY; c++) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            m = c / WY; j = c % WY;
            exp_col = '0;
            for (int i = 0; i < WX; i++) exp_col[i] = rows[m * WX + i][j];
            exp_ir   = (c >= WY);
            exp_last = (j == WY - 1);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid col %0d: got %b want 1", c, out_valid); end
            tests++; if (out_data !== exp_col) begin fails++; $display("FAIL bp_col %0d: got %b want %b", c, out_data, exp_col); end
            tests++; if (out_last !== exp_last) begin fails++; $display("FAIL bp_last col %0d: got %b want %b", c, out_last, exp_last); end
            tests++; if (in_ready !== exp_ir) begin fails++; $display("FAIL bp_ready_return col %0d: got %b want %b", c, in_ready, exp_ir); end
        end
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_random_stress();
        logic [WY-1:0] part [$];
        logic [WX-1:0] colq [$];
        logic [WX-1:0] c;
        logic [WX-1:0] prev_od;
        logic [WY-1:0] din;
        logic          prev_hold;
        logic          iv;
        logic          ordy;
        logic          exp_ir;
        logic          exp_ov;
        logic          exp_last;
        int            pending;
        int            colidx;
        int            rows_left;
        int            cols_left;
        int            cyc;
        pending = 0; colidx = 0; cyc = 0; prev_hold = 1'b0; prev_od = '0;
        rows_left = 200 * WX; cols_left = 200 * WY;
        while (cols_left > 0 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            iv   = (rows_left > 0) && ($urandom_range(0, 3) != 0);
            din  = WY'($urandom);
            ordy = ($urandom_range(0, 2) != 0);
            flush = 1'b0; in_valid = iv; in_data = din; out_ready = ordy;
            exp_ir = (pending < 2);
            exp_ov = (pending > 0);
            tests++; if (in_ready !== exp_ir) begin fails++; $display("FAIL stress_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_ir); end
            tests++; if (out_valid !== exp_ov) begin fails++; $display("FAIL stress_out_valid cyc %0d: got %b want %b", cyc, out_valid, exp_ov); end
            if (exp_ov) begin
                exp_last = (colidx == WY - 1);
                tests++; if (out_data !== colq[0]) begin fails++; $display("FAIL stress_col cyc %0d: got %b want %b", cyc, out_data, colq[0]); end
                tests++; if (out_last !== exp_last) begin fails++; $display("FAIL stress_last cyc %0d: got %b want %b", cyc, out_last, exp_last); end
            end
            if (prev_hold) begin
                tests++; if (out_data !== prev_od) begin fails++; $display("FAIL stress_stable cyc %0d: got %b want %b", cyc, out_data, prev_od); end
            end
            prev_hold = exp_ov && !ordy;
            prev_od   = out_data;
            if (iv && exp_ir) begin
                part.push_back(din);
                rows_left--;
                if (part.size() == WX) begin
                    for (int j = 0; j < WY; j++) begin
                        c = '0;
                        for (int i = 0; i < WX; i++) c[i] = part[i][j];
                        colq.push_back(c);
                    end
                    pending++;
                    part.delete();
                end
            end
            if (exp_ov && ordy) begin
                void'(colq.pop_front());
                cols_left--;
                colidx++;
                if (colidx == WY) begin
                    colidx = 0;
                    pending--;
                end
            end
        end
        tests++; if (cols_left != 0) begin fails++; $display("FAIL stress_timeout: got %0d columns left want 0", cols_left); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_flush_mid_fill();
        logic exp_last;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            flush = 1'b0; in_valid = 1'b1; in_data = WY'($urandom); out_ready = 1'b1;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_a_ready row %0d: got %b want 1", k, in_ready); end
        end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_data = WY'($urandom);
        for (int k = 0; k < WX; k++) begin
            @(negedge clk);
            flush = 1'b0; in_valid = 1'b1; in_data = single_rows[k]; out_ready = 1'b1;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready row %0d: got %b want 1", k, in_ready); end
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_stale_valid row %0d: got %b want 0", k, out_valid); end
        end
        for (int c = 0; c < WY; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            exp_last = (c == WY - 1);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL flush_out_valid col %0d: got %b want 1", c, out_valid); end
            tests++; if (out_data !== single_cols[c]) begin fails++; $display("FAIL flush_col %0d: got %b want %b", c, out_data, single_cols[c]); end
            tests++; if (out_last !== exp_last) begin fails++; $display("FAIL flush_last col %0d: got %b want %b", c, out_last, exp_last); end
        end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset_mid_drain();
        logic [WY-1:0] ar [WX];
        logic [WY-1:0] br [WX];
        logic [WX-1:0] exp_col;
        logic          exp_last;
        for (int k = 0; k < WX; k++) begin
            @(negedge clk);
            ar[k] = WY'($urandom);
            in_valid = 1'b1; in_data = ar[k]; out_ready = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            exp_col = transpose_col(ar, c);
            tests++; if (out_data !== exp_col) begin fails++; $display("FAIL arst_pre_col %0d: got %b want %b", c, out_data, exp_col); end
        end
        @(negedge clk);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
        tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL arst_out_last: got %b want 0", out_last); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_hold_valid: got %b want 0", out_valid); end
        rst_n = 1'b1;
        for (int k = 0; k < WX; k++) begin
            if (k != 0) @(negedge clk);
            br[k] = WY'($urandom);
            in_valid = 1'b1; in_data = br[k]; out_ready = 1'b1;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL arst_new_ready row %0d: got %b want 1", k, in_ready); end
        end
        for (int c = 0; c < WY; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            exp_col  = transpose_col(br, c);
            exp_last = (c == WY - 1);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL arst_new_valid col %0d: got %b want 1", c, out_valid); end
            tests++; if (out_data !== exp_col) begin fails++; $display("FAIL arst_new_col %0d: got %b want %b", c, out_data, exp_col); end
            tests++; if (out_last !== exp_last) begin fails++; $display("FAIL arst_new_last col %0d: got %b want %b", c, out_last, exp_last); end
        end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_drained: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_matrix();
        test_backpressure();
        test_random_stress();
        test_flush_mid_fill();
        test_async_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
